frame_scheduler: RTL and testbench
==================================

Name: frame_scheduler

Overview:
Sequences the raster coordinate generator into discrete frames for the downstream pixel pipeline. Holds the generator at its origin while idle and starts frames on command, in single-shot or continuous mode. Inserts programmable horizontal and vertical blanking gaps. Passes coordinate beats through with valid/ready and sideband flags (start-of-frame, end-of-line, end-of-frame). Sits between coordinate_gen and the per-pixel compute pipeline.

Parameters:
LINES, 512, active lines per frame (number of gen_lastx beats that make up one frame)
H_BLANK, 4, idle cycles inserted after each non-final line; 0 = none
V_BLANK, 16, idle cycles inserted after the final line; 0 = none
CNT_W, 16, width of line_idx, frame_cnt and blank counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  pulse; begins a frame when IDLE
continuous  in  1  level; sampled at end of VBLANK; 1 = start the next frame automatically
stop  in  1  pulse; request to return to IDLE after the current frame
gen_valid  in  1  generator beat valid
gen_lastx  in  1  generator beat is last pixel of a line
gen_ready  out  1  ready to generator
gen_resetn  out  1  registered sync reset to generator, active-low
m_valid  out  1  beat valid to pipeline
m_ready  in  1  pipeline ready
m_sof  out  1  beat is first of frame
m_eol  out  1  beat is last of line
m_eof  out  1  beat is last of frame
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse after the final beat of a frame
line_idx  out  CNT_W  current line, 0..LINES-1
frame_cnt  out  CNT_W  completed frames; wraps modulo 2^CNT_W

Behaviour:
- Reset (async): state=IDLE; gen_resetn=0; frame_done=0; line_idx=0; frame_cnt=0; stop_pending=0; sof_flag=1; blank counter=0.
- State IDLE:
  - gen_resetn=0, gen_ready=0, m_valid=0.
  - start=1 at edge t -> ACTIVE from cycle t+1, and gen_resetn=1 from t+1.
  - The generator is therefore at its origin when the first beat appears in cycle t+1.
  - stop is ignored in IDLE.
- State ACTIVE:
  - Combinational pass-through: m_valid=gen_valid; gen_ready=m_ready.
  - Beat = gen_valid && m_ready.
  - m_sof=sof_flag; m_eol=gen_lastx; m_eof=gen_lastx && line_idx==LINES-1. All three are qualified by m_valid.
  - sof_flag is cleared on the first beat and set again on entry to a new frame.
  - Beat with gen_lastx on a non-final line: line_idx+1; enter HBLANK (counter=H_BLANK-1) if H_BLANK>0, else remain in ACTIVE.
  - Beat with gen_lastx on the final line: frame_done=1 next cycle; frame_cnt+1; line_idx=0; enter VBLANK (counter=V_BLANK-1) if V_BLANK>0, else apply the VBLANK exit rule immediately.
- States HBLANK and VBLANK:
  - gen_ready=0, m_valid=0. The generator holds its coordinate.
  - The counter decrements each cycle; exit on the cycle it reads 0. Each gap lasts exactly H_BLANK or V_BLANK cycles.
  - HBLANK exit -> ACTIVE.
  - VBLANK exit: if continuous && !stop_pending -> ACTIVE with sof_flag=1. The generator has wrapped to its origin on its own; gen_resetn stays 1.
  - Otherwise VBLANK exit -> IDLE with gen_resetn=0.
- stop: when busy, sets stop_pending, which is cleared on entry to IDLE. The current frame always completes. start while busy is ignored.
- Backpressure: m_ready=0 in ACTIVE stalls both the generator and the line accounting. No beat is ever dropped or duplicated.
- Counter widths: line_idx and frame_cnt are CNT_W bits, unsigned. frame_cnt wraps from 2^CNT_W-1 to 0.
- frame_done is registered, high for exactly 1 cycle per completed frame.

Test Plan:
- Single-shot, mock generator (lastx every 4th beat), LINES=3, H_BLANK=2, V_BLANK=3, m_ready=1; start pulse -> 12 beats; m_sof on beat 1 only; m_eol on beats 4/8/12; m_eof on beat 12; 2-cycle gaps after lines 0 and 1; frame_done one cycle after beat 12; frame_cnt=1; IDLE with gen_resetn=0 after 3 VBLANK cycles.
- Continuous, 3 frames, then stop pulse mid-frame 3 -> frame 3 completes; frame_cnt=3; then IDLE; exactly 36 beats total with no extra beats.
- Random m_ready toggling (50%) during a frame -> beat sequence and flags identical to the m_ready=1 run; gen_ready==m_ready whenever ACTIVE.
- H_BLANK=0, V_BLANK=0, continuous -> no idle cycles between lines or frames; m_sof is on the beat directly after m_eof.
- Async reset asserted mid-line -> all outputs reach reset values immediately; start after release -> new frame begins at line_idx=0 with m_sof=1.
- With the real coordinate_gen, LINES=512 -> first beat (-256,256); m_eof on (255,-255); 262144 beats per frame.

Source files
------------

// File: rtl/frame_scheduler.sv
// frame_scheduler: sequences raster coordinate beats into frames.
// Holds the coordinate generator at its origin while idle. Once started it
// passes generator beats through to the pixel pipeline and adds the
// start-of-frame, end-of-line and end-of-frame flags. It inserts the
// horizontal and vertical blanking gaps, and runs single-shot or continuous.
module frame_scheduler #(
  parameter int LINES   = 512,
  parameter int H_BLANK = 4,
  parameter int V_BLANK = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic             stop,
  input  logic             gen_valid,
  input  logic             gen_lastx,
  output logic             gen_ready,
  output logic             gen_resetn,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_sof,
  output logic             m_eol,
  output logic             m_eof,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] line_idx,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_e;

  localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(LINES - 1);
  // Gap counters are loaded with length-1 so that a gap of N cycles ends
  // on the cycle the counter reads zero.
  localparam logic [CNT_W-1:0] H_LOAD    = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] V_LOAD    = CNT_W'(V_BLANK - 1);

  state_e           state_q, state_d;
  logic             gen_resetn_q, gen_resetn_d;
  logic             frame_done_q, frame_done_d;
  logic [CNT_W-1:0] line_idx_q, line_idx_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             stop_pending_q, stop_pending_d;
  logic             sof_flag_q, sof_flag_d;
  logic [CNT_W-1:0] blank_q, blank_d;
  logic             frame_end;
  logic             active;

  // State register: all sequential state, async reset to the idle/origin values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      gen_resetn_q   <= 1'b0;
      frame_done_q   <= 1'b0;
      line_idx_q     <= '0;
      frame_cnt_q    <= '0;
      stop_pending_q <= 1'b0;
      sof_flag_q     <= 1'b1;
      blank_q        <= '0;
    end else begin
      state_q        <= state_d;
      gen_resetn_q   <= gen_resetn_d;
      frame_done_q   <= frame_done_d;
      line_idx_q     <= line_idx_d;
      frame_cnt_q    <= frame_cnt_d;
      stop_pending_q <= stop_pending_d;
      sof_flag_q     <= sof_flag_d;
      blank_q        <= blank_d;
    end
  end

  // Next-state: frame/line accounting, blanking counters and end-of-frame decision
  always_comb begin
    state_d        = state_q;
    gen_resetn_d   = gen_resetn_q;
    frame_done_d   = 1'b0;
    line_idx_d     = line_idx_q;
    frame_cnt_d    = frame_cnt_q;
    stop_pending_d = stop_pending_q;
    sof_flag_d     = sof_flag_q;
    blank_d        = blank_q;
    frame_end      = 1'b0;

    if (state_q != S_IDLE && stop) stop_pending_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_ACTIVE;
          gen_resetn_d = 1'b1;
          sof_flag_d   = 1'b1;
        end
      end
      S_ACTIVE: begin
        // Accounting advances only on an accepted beat, so backpressure
        // stalls it together with the generator.
        if (gen_valid && m_ready) begin
          sof_flag_d = 1'b0;
          if (gen_lastx) begin
            if (line_idx_q == LAST_LINE) begin
              frame_done_d = 1'b1;
              frame_cnt_d  = frame_cnt_q + 1'b1;
              line_idx_d   = '0;
              if (V_BLANK > 0) begin
                state_d = S_VBLANK;
                blank_d = V_LOAD;
              end else begin
                frame_end = 1'b1;
              end
            end else begin
              line_idx_d = line_idx_q + 1'b1;
              if (H_BLANK > 0) begin
                state_d = S_HBLANK;
                blank_d = H_LOAD;
              end
            end
          end
        end
      end
      S_HBLANK: begin
        if (blank_q == '0) state_d = S_ACTIVE;
        else               blank_d = blank_q - 1'b1;
      end
      S_VBLANK: begin
        if (blank_q == '0) frame_end = 1'b1;
        else               blank_d   = blank_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Frame boundary: either roll straight into the next frame (the generator
    // has already wrapped to its origin) or park in IDLE holding it in reset.
    if (frame_end) begin
      sof_flag_d = 1'b1;
      if (continuous && !stop_pending_q) begin
        state_d = S_ACTIVE;
      end else begin
        state_d        = S_IDLE;
        gen_resetn_d   = 1'b0;
        stop_pending_d = 1'b0;
      end
    end
  end

  // Outputs: combinational pass-through while ACTIVE, flags qualified by m_valid
  always_comb begin
    active    = (state_q == S_ACTIVE);
    m_valid   = active & gen_valid;
    gen_ready = active & m_ready;
    m_sof     = m_valid & sof_flag_q;
    m_eol     = m_valid & gen_lastx;
    m_eof     = m_valid & gen_lastx & (line_idx_q == LAST_LINE);
    busy      = (state_q != S_IDLE);
  end

  assign gen_resetn = gen_resetn_q;
  assign frame_done = frame_done_q;
  assign line_idx   = line_idx_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler. Two instances share the clock and reset:
//   a: LINES=3, H_BLANK=2, V_BLANK=3
//   b: LINES=3, no blanking
// Each instance is fed by a mock generator that asserts lastx on every 4th
// accepted beat, so one frame is 12 beats.
module tb_frame_scheduler;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start_a = 0, cont_a = 0, stop_a = 0, m_ready_a = 1;
  logic gen_valid_a, gen_lastx_a, gen_ready_a, gen_resetn_a;
  logic m_valid_a, m_sof_a, m_eol_a, m_eof_a, busy_a, fd_a;
  logic [CW-1:0] line_a, fcnt_a;

  logic start_b = 0, cont_b = 0, stop_b = 0, m_ready_b = 1;
  logic gen_valid_b, gen_lastx_b, gen_ready_b, gen_resetn_b;
  logic m_valid_b, m_sof_b, m_eol_b, m_eof_b, busy_b, fd_b;
  logic [CW-1:0] line_b, fcnt_b;

  int tests = 0;
  int errors = 0;

  frame_scheduler #(.LINES(3), .H_BLANK(2), .V_BLANK(3), .CNT_W(CW)) u_a (
    .clk(clk), .reset(rst), .start(start_a), .continuous(cont_a), .stop(stop_a),
    .gen_valid(gen_valid_a), .gen_lastx(gen_lastx_a), .gen_ready(gen_ready_a),
    .gen_resetn(gen_resetn_a), .m_valid(m_valid_a), .m_ready(m_ready_a),
    .m_sof(m_sof_a), .m_eol(m_eol_a), .m_eof(m_eof_a), .busy(busy_a),
    .frame_done(fd_a), .line_idx(line_a), .frame_cnt(fcnt_a));

  frame_scheduler #(.LINES(3), .H_BLANK(0), .V_BLANK(0), .CNT_W(CW)) u_b (
    .clk(clk), .reset(rst), .start(start_b), .continuous(cont_b), .stop(stop_b),
    .gen_valid(gen_valid_b), .gen_lastx(gen_lastx_b), .gen_ready(gen_ready_b),
    .gen_resetn(gen_resetn_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
    .m_sof(m_sof_b), .m_eol(m_eol_b), .m_eof(m_eof_b), .busy(busy_b),
    .frame_done(fd_b), .line_idx(line_b), .frame_cnt(fcnt_b));

  // Mock generators: 4 pixels per line, always valid, sync active-low reset
  logic [1:0] xa = 2'd0;
  logic [1:0] xb = 2'd0;
  always @(posedge clk) begin
    if (!gen_resetn_a) xa <= 2'd0;
    else if (gen_ready_a && gen_valid_a) xa <= xa + 2'd1;
  end
  always @(posedge clk) begin
    if (!gen_resetn_b) xb <= 2'd0;
    else if (gen_ready_b && gen_valid_b) xb <= xb + 2'd1;
  end
  assign gen_valid_a = 1'b1;
  assign gen_lastx_a = (xa == 2'd3);
  assign gen_valid_b = 1'b1;
  assign gen_lastx_b = (xb == 2'd3);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor a: counts beats/gaps/done pulses and checks per-beat flags
  int ep_a = 0, seen_a = 0;
  int beats_a = 0, busy_cyc_a = 0, gaps_a = 0, fd_n_a = 0, cyc_a = 0;
  int last_beat_cyc_a = 0, fd_cyc_a = 0;
  always @(negedge clk) begin
    if (ep_a != seen_a) begin
      seen_a = ep_a; beats_a = 0; busy_cyc_a = 0; gaps_a = 0; fd_n_a = 0;
    end
    cyc_a++;
    if (busy_a) busy_cyc_a++;
    if (busy_a && !m_valid_a) gaps_a++;
    if (fd_a) begin fd_n_a++; fd_cyc_a = cyc_a; end
    if (m_valid_a) chk("a_gen_ready", 32'(gen_ready_a), 32'(m_ready_a));
    else           chk("a_gen_ready_off", 32'(gen_ready_a), 32'd0);
    if (m_valid_a && m_ready_a) begin
      chk("a_sof",  32'(m_sof_a), 32'(beats_a % 12 == 0));
      chk("a_eol",  32'(m_eol_a), 32'(beats_a % 4 == 3));
      chk("a_eof",  32'(m_eof_a), 32'(beats_a % 12 == 11));
      chk("a_line", 32'(line_a),  32'((beats_a % 12) / 4));
      beats_a++;
      last_beat_cyc_a = cyc_a;
    end
  end

  // Monitor b: same checks for the no-blanking instance
  int ep_b = 0, seen_b = 0;
  int beats_b = 0, busy_cyc_b = 0, gaps_b = 0, fd_n_b = 0;
  always @(negedge clk) begin
    if (ep_b != seen_b) begin
      seen_b = ep_b; beats_b = 0; busy_cyc_b = 0; gaps_b = 0; fd_n_b = 0;
    end
    if (busy_b) busy_cyc_b++;
    if (busy_b && !m_valid_b) gaps_b++;
    if (fd_b) fd_n_b++;
    if (m_valid_b && m_ready_b) begin
      chk("b_sof",  32'(m_sof_b), 32'(beats_b % 12 == 0));
      chk("b_eol",  32'(m_eol_b), 32'(beats_b % 4 == 3));
      chk("b_eof",  32'(m_eof_b), 32'(beats_b % 12 == 11));
      chk("b_line", 32'(line_b),  32'((beats_b % 12) / 4));
      beats_b++;
    end
  end

  initial begin
    // Reset state
    repeat (3) tick;
    chk("rst_busy",   32'(busy_a), 32'd0);
    chk("rst_resetn", 32'(gen_resetn_a), 32'd0);
    chk("rst_done",   32'(fd_a), 32'd0);
    chk("rst_line",   32'(line_a), 32'd0);
    chk("rst_fcnt",   32'(fcnt_a), 32'd0);
    chk("rst_valid",  32'(m_valid_a), 32'd0);
    rst = 1'b0;
    tick;

    // Single-shot frame: 12 beats, 2+2+3 gap cycles, 19 busy cycles
    ep_a++;
    start_a = 1; tick; start_a = 0;
    for (int i = 0; i < 60 && busy_a; i++) tick;
    chk("ss_idle",    32'(busy_a), 32'd0);
    chk("ss_beats",   32'(beats_a), 32'd12);
    chk("ss_busycyc", 32'(busy_cyc_a), 32'd19);
    chk("ss_gaps",    32'(gaps_a), 32'd7);
    chk("ss_fd_n",    32'(fd_n_a), 32'd1);
    chk("ss_fd_lat",  32'(fd_cyc_a - last_beat_cyc_a), 32'd1);
    chk("ss_fcnt",    32'(fcnt_a), 32'd1);
    chk("ss_resetn",  32'(gen_resetn_a), 32'd0);

    // Continuous, stop during frame 3: exactly 36 beats then idle
    ep_a++;
    cont_a = 1;
    start_a = 1; tick; start_a = 0;
    for (int i = 0; i < 200 && beats_a < 28; i++) tick;
    stop_a = 1; tick; stop_a = 0;
    for (int i = 0; i < 200 && busy_a; i++) tick;
    cont_a = 0;
    repeat (10) tick;
    chk("ct_idle",   32'(busy_a), 32'd0);
    chk("ct_beats",  32'(beats_a), 32'd36);
    chk("ct_fd_n",   32'(fd_n_a), 32'd3);
    chk("ct_gaps",   32'(gaps_a), 32'd21);
    chk("ct_fcnt",   32'(fcnt_a), 32'd4);
    chk("ct_resetn", 32'(gen_resetn_a), 32'd0);

    // Random backpressure: same beat sequence, nothing dropped or duplicated
    ep_a++;
    start_a = 1; m_ready_a = 1'($urandom_range(0, 1)); tick; start_a = 0;
    for (int i = 0; i < 300 && busy_a; i++) begin
      m_ready_a = 1'($urandom_range(0, 1));
      tick;
    end
    m_ready_a = 1;
    tick;
    chk("bp_idle",  32'(busy_a), 32'd0);
    chk("bp_beats", 32'(beats_a), 32'd12);
    chk("bp_fd_n",  32'(fd_n_a), 32'd1);
    chk("bp_fcnt",  32'(fcnt_a), 32'd5);

    // No blanking, continuous for 2 frames: zero idle cycles, sof right after eof
    ep_b++;
    cont_b = 1;
    start_b = 1; tick; start_b = 0;
    for (int i = 0; i < 100 && beats_b < 14; i++) tick;
    stop_b = 1; tick; stop_b = 0;
    for (int i = 0; i < 100 && busy_b; i++) tick;
    cont_b = 0;
    tick;
    chk("nb_idle",    32'(busy_b), 32'd0);
    chk("nb_beats",   32'(beats_b), 32'd24);
    chk("nb_gaps",    32'(gaps_b), 32'd0);
    chk("nb_busycyc", 32'(busy_cyc_b), 32'd24);
    chk("nb_fd_n",    32'(fd_n_b), 32'd2);
    chk("nb_fcnt",    32'(fcnt_b), 32'd2);
    chk("nb_resetn",  32'(gen_resetn_b), 32'd0);

    // Async reset in the middle of line 1, then a clean frame
    ep_a++;
    start_a = 1; tick; start_a = 0;
    for (int i = 0; i < 60 && beats_a < 6; i++) tick;
    #2 rst = 1'b1;
    #1;
    chk("ar_busy",   32'(busy_a), 32'd0);
    chk("ar_resetn", 32'(gen_resetn_a), 32'd0);
    chk("ar_line",   32'(line_a), 32'd0);
    chk("ar_fcnt",   32'(fcnt_a), 32'd0);
    chk("ar_valid",  32'(m_valid_a), 32'd0);
    chk("ar_done",   32'(fd_a), 32'd0);
    tick; tick;
    rst = 1'b0;
    tick;
    ep_a++;
    start_a = 1; tick; start_a = 0;
    for (int i = 0; i < 60 && busy_a; i++) tick;
    tick;
    chk("ar2_idle",  32'(busy_a), 32'd0);
    chk("ar2_beats", 32'(beats_a), 32'd12);
    chk("ar2_fd_n",  32'(fd_n_a), 32'd1);
    chk("ar2_fcnt",  32'(fcnt_a), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
